vec_load_sequencer: RTL and testbench
=====================================

Name: vec_load_sequencer

Overview:
- Initiator/writer side of the multi-resource compute core's load interface.
- Accepts a valid/ready stream of (a,b) operand pairs and drives the core's we/index/a_data/b_data/n write port.
- After the last pair it releases the write port, waits for the core's done, and reports completion, error flags and elapsed cycle count to the controller.

Parameters:
- DEPTH, 1024, operand memory depth in the core; index width is clog2(DEPTH) = 10.
- TIMEOUT, 65535, maximum cycles in RUN waiting for done before timeout_err is raised.

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a load/run job
- in_valid  in  1  upstream pair valid
- in_ready  out  1  sequencer ready to accept a pair
- in_a  in  32  operand a
- in_b  in  32  operand b
- in_last  in  1  marks final pair of the job
- we  out  1  core write enable
- index  out  10  core write address
- a_data  out  32  core operand a write data
- b_data  out  32  core operand b write data
- n  out  32  last valid index (element count minus 1), held stable from end of LOAD through DONE
- done  in  1  core computation complete (level)
- busy  out  1  job in progress (LOAD or RUN)
- complete  out  1  one-cycle pulse on job end (normal or timeout)
- timeout_err  out  1  sticky until next start; done not seen within TIMEOUT cycles
- overflow  out  1  sticky until next start; DEPTH pairs accepted without in_last
- cycles  out  32  cycles spent in RUN, valid when complete pulses, held afterwards

Behaviour:
- Reset values:
  - in_ready=0, we=0, index=0, a_data=0, b_data=0, n=0.
  - busy=0, complete=0, timeout_err=0, overflow=0, cycles=0.
  - State = IDLE.
- IDLE:
  - in_ready=0.
  - On start: clear timeout_err, overflow, cycles and the write counter; go to LOAD.
- LOAD:
  - in_ready=1, busy=1.
  - A handshake is in_valid&&in_ready in a cycle. Each handshake registers we=1, index=counter, a_data=in_a, b_data=in_b, visible the next cycle (latency 1), then increments the counter.
  - In cycles without a handshake, we=0 the next cycle; index and data hold their values.
  - If the handshake has in_last=1: n<=counter, in_ready drops the next cycle, go to RUN.
  - If the handshake is at counter==DEPTH-1 without in_last: same as in_last, but also set overflow=1.
- RUN:
  - in_ready=0, we=0 (after the final write cycle), busy=1.
  - cycles increments every cycle.
  - done=1: complete pulses 1 cycle, go to DONE.
  - cycles reaching TIMEOUT with no done: timeout_err=1, complete pulses, go to DONE.
  - done and the timeout on the same cycle: treated as normal completion, timeout_err stays 0.
- DONE:
  - busy=0; n, cycles and flags held.
  - Next start behaves as from IDLE (direct to LOAD).
  - done remaining high is ignored.
- Ignored events:
  - start while busy is ignored.
  - done asserted during LOAD is ignored; no early exit.
- Single-pair job (first pair has in_last): one write at index 0, n=0.
- Reset mid-LOAD or mid-RUN:
  - Next cycle we=0, in_ready=0, busy=0, state IDLE.
  - No complete pulse; partial writes are abandoned.
- Width rules:
  - index wraps never; capped by overflow handling.
  - n is zero-extended from 10 bits.
  - cycles saturates at 2^32-1.

Test Plan:
- Reset, start, stream 15 pairs a=10,20..150, b=2,3..16 with in_last on the 15th, in_valid held high -> 15 consecutive we pulses at index 0..14 with matching data, n=14; done raised 40 cycles later -> complete pulse, cycles=40, flags 0.
- Same stream with in_valid deasserted on every other cycle -> we gaps track the gaps, index still 0..14 contiguous, no pair lost or duplicated.
- Stream 1024 pairs with no in_last -> overflow=1, n=1023, in_ready low after the 1024th handshake, RUN entered.
- TIMEOUT=100, done never asserted -> timeout_err=1, complete pulses exactly once at RUN cycle 100, then busy=0.
- start pulsed during LOAD, and done pulsed during LOAD -> both ignored; the job completes normally with the correct n.
- Assert rst after the 5th handshake -> next cycle we=0, busy=0, in_ready=0; a new start with 3 pairs gives index 0..2 and n=2.

Source files
------------

// File: rtl/vec_load_sequencer.sv
// Writer side of the compute core's load port: streams (a,b) pairs into operand memory,
// waits for the core's done and reports completion, error flags and RUN cycle count.
module vec_load_sequencer #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_a,
    input  logic [31:0]              in_b,
    input  logic                     in_last,
    output logic                     we,
    output logic [$clog2(DEPTH)-1:0] index,
    output logic [31:0]              a_data,
    output logic [31:0]              b_data,
    output logic [31:0]              n,
    input  logic                     done,
    output logic                     busy,
    output logic                     complete,
    output logic                     timeout_err,
    output logic                     overflow,
    output logic [31:0]              cycles
);

    localparam int unsigned IW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e        state;
    logic [IW-1:0] count;
    logic          hs;
    logic          final_pair;
    logic [31:0]   cycles_inc;

    always_comb begin
        hs         = in_valid && in_ready;
        final_pair = in_last || (count == IW'(DEPTH - 1));
        // Saturate rather than wrap so a stuck core never reports a tiny count
        cycles_inc = (cycles == 32'hFFFF_FFFF) ? cycles : cycles + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            count       <= '0;
            in_ready    <= 1'b0;
            we          <= 1'b0;
            index       <= '0;
            a_data      <= '0;
            b_data      <= '0;
            n           <= '0;
            busy        <= 1'b0;
            complete    <= 1'b0;
            timeout_err <= 1'b0;
            overflow    <= 1'b0;
            cycles      <= '0;
        end else begin
            complete <= 1'b0;
            we       <= 1'b0;
            case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state       <= StLoad;
                        count       <= '0;
                        in_ready    <= 1'b1;
                        busy        <= 1'b1;
                        timeout_err <= 1'b0;
                        overflow    <= 1'b0;
                        cycles      <= '0;
                    end
                end
                StLoad: begin
                    if (hs) begin
                        we     <= 1'b1;
                        index  <= count;
                        a_data <= in_a;
                        b_data <= in_b;
                        if (final_pair) begin
                            // Memory full without in_last: close the job and flag it
                            n        <= 32'(count);
                            overflow <= !in_last;
                            in_ready <= 1'b0;
                            state    <= StRun;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                StRun: begin
                    cycles <= cycles_inc;
                    if (done) begin
                        complete <= 1'b1;
                        busy     <= 1'b0;
                        state    <= StDone;
                    end else if (cycles_inc >= TIMEOUT) begin
                        timeout_err <= 1'b1;
                        complete    <= 1'b1;
                        busy        <= 1'b0;
                        state       <= StDone;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_load_sequencer.sv
// Scoreboard bench for vec_load_sequencer: expected writes and completions are queued by the
// stimulus and popped by a monitor whenever the DUT shows we or complete.
module tb_vec_load_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_ready, in_last, we, done;
    logic        busy, complete, timeout_err, overflow;
    logic [31:0] in_a, in_b, a_data, b_data, n, cycles;
    logic [9:0]  index;

    typedef struct {
        logic [9:0]  idx;
        logic [31:0] a;
        logic [31:0] b;
    } wr_t;

    typedef struct {
        logic [31:0] n;
        logic [31:0] cyc;
        logic        to;
        logic        ov;
    } cmp_t;

    wr_t  wr_q[$];
    cmp_t cmp_q[$];
    int   checks   = 0;
    int   failures = 0;

    vec_load_sequencer #(.DEPTH(1024), .TIMEOUT(100)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .we(we), .index(index),
        .a_data(a_data), .b_data(b_data), .n(n), .done(done), .busy(busy),
        .complete(complete), .timeout_err(timeout_err), .overflow(overflow), .cycles(cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are registered, so sampling on the falling edge is race-free
    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (wr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: index=%0d a=0x%0h, expected none", index, a_data);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                check("wr_index", 32'(index), 32'(e.idx));
                check("wr_a", a_data, e.a);
                check("wr_b", b_data, e.b);
            end
        end
        if (complete === 1'b1) begin
            if (cmp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_complete: cycles=%0d, expected no pulse", cycles);
            end else begin
                cmp_t c;
                c = cmp_q.pop_front();
                check("cmp_n", n, c.n);
                check("cmp_cycles", cycles, c.cyc);
                check("cmp_timeout_err", 32'(timeout_err), 32'(c.to));
                check("cmp_overflow", 32'(overflow), 32'(c.ov));
                check("cmp_busy", 32'(busy), 32'd0);
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("load_in_ready", 32'(in_ready), 32'd1);
        check("load_busy", 32'(busy), 32'd1);
        check("start_clears_ov", 32'(overflow), 32'd0);
        check("start_clears_to", 32'(timeout_err), 32'd0);
        check("start_clears_cyc", cycles, 32'd0);
    endtask

    // Pair i carries a=(i+1)*10, b=i+2; inject puts a start and a done pulse mid-LOAD
    task automatic send_pairs(input int cnt, input bit with_last, input bit gaps,
                              input bit inject);
        int  i     = 0;
        int  guard = 0;
        bit  phase = 1'b0;
        while (i < cnt) begin
            start = inject && (guard == 3);
            done  = inject && (guard == 6);
            if (gaps && phase) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_a     = (i + 1) * 10;
                in_b     = i + 2;
                in_last  = with_last && (i == cnt - 1);
            end
            phase = ~phase;
            if (in_valid && in_ready) begin
                wr_q.push_back('{idx: 10'(i), a: in_a, b: in_b});
                i++;
            end
            @(negedge clk);
            guard++;
            if (guard > cnt * 3 + 20) begin
                checks++;
                failures++;
                $display("FAIL stream_stall: sent %0d pairs, expected %0d", i, cnt);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
        done     = 1'b0;
    endtask

    // done is sampled high on the k-th RUN clock edge
    task automatic run_done(input int k);
        done = 1'b0;
        repeat (k - 1) @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("complete_pulse", 32'(complete), 32'd1);
        @(negedge clk);
        check("complete_single", 32'(complete), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; done = 1'b0;
        in_a = '0; in_b = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_index", 32'(index), 32'd0);
        check("rst_a_data", a_data, 32'd0);
        check("rst_b_data", b_data, 32'd0);
        check("rst_n", n, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_complete", 32'(complete), 32'd0);
        check("rst_cycles", cycles, 32'd0);
        check("rst_flags", 32'({timeout_err, overflow}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 15 back-to-back pairs, done on RUN cycle 40
        do_start();
        send_pairs(15, 1'b1, 1'b0, 1'b0);
        check("t1_in_ready_low", 32'(in_ready), 32'd0);
        check("t1_busy_run", 32'(busy), 32'd1);
        check("t1_n", n, 32'd14);
        cmp_q.push_back('{n: 32'd14, cyc: 32'd40, to: 1'b0, ov: 1'b0});
        run_done(40);

        // Same stream with bubbles, started from DONE
        do_start();
        send_pairs(15, 1'b1, 1'b1, 1'b0);
        check("t2_n", n, 32'd14);
        cmp_q.push_back('{n: 32'd14, cyc: 32'd3, to: 1'b0, ov: 1'b0});
        run_done(3);

        // Overflow: 1024 pairs, no in_last
        do_start();
        send_pairs(1024, 1'b0, 1'b0, 1'b0);
        check("t3_in_ready_low", 32'(in_ready), 32'd0);
        check("t3_busy_run", 32'(busy), 32'd1);
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_n", n, 32'd1023);
        cmp_q.push_back('{n: 32'd1023, cyc: 32'd10, to: 1'b0, ov: 1'b1});
        run_done(10);
        check("t3_overflow_sticky", 32'(overflow), 32'd1);

        // Timeout at RUN cycle 100
        do_start();
        send_pairs(4, 1'b1, 1'b0, 1'b0);
        cmp_q.push_back('{n: 32'd3, cyc: 32'd100, to: 1'b1, ov: 1'b0});
        begin
            int cnt = 0;
            while (complete !== 1'b1 && cnt < 200) begin
                @(negedge clk);
                cnt++;
            end
            check("t4_timeout_cycle", 32'(cnt), 32'd100);
        end
        repeat (5) @(negedge clk);
        check("t4_busy_done", 32'(busy), 32'd0);
        check("t4_timeout_sticky", 32'(timeout_err), 32'd1);

        // start and done pulsed during LOAD are ignored
        do_start();
        send_pairs(15, 1'b1, 1'b0, 1'b1);
        check("t5_n", n, 32'd14);
        check("t5_busy_run", 32'(busy), 32'd1);
        cmp_q.push_back('{n: 32'd14, cyc: 32'd7, to: 1'b0, ov: 1'b0});
        run_done(7);

        // Reset after the 5th handshake, then a fresh 3-pair job
        do_start();
        send_pairs(5, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_we", 32'(we), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd0);
        check("t6_complete", 32'(complete), 32'd0);
        @(negedge clk);
        do_start();
        send_pairs(3, 1'b1, 1'b0, 1'b0);
        check("t6_n", n, 32'd2);
        cmp_q.push_back('{n: 32'd2, cyc: 32'd5, to: 1'b0, ov: 1'b0});
        run_done(5);

        repeat (3) @(negedge clk);
        check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        check("cmp_queue_drained", 32'(cmp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
        $fatal(1, "watchdog");
    end

endmodule
